inf_key_ctrl: RTL and testbench

//  Key-event sequencer behind the NEC IR receiver. Turns decoded frames and repeat codes

---
 rtl/inf_key_ctrl_if.sv | 22 ++
 rtl/inf_key_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_inf_key_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inf_key_ctrl_if.sv
// Bus between the NEC frame decoder / event consumer and inf_key_ctrl.
// The master side drives decoded frames, repeat indication and the consumer's
// ready. The slave side (the key controller) returns the head of its event FIFO.
interface inf_key_ctrl_if;
  logic       frame_vld;
  logic [7:0] cmd;
  logic       repeat_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [7:0] evt_code;

  modport master (
    output frame_vld, cmd, repeat_en, evt_ready,
    input  evt_valid, evt_type, evt_code
  );

  modport slave (
    input  frame_vld, cmd, repeat_en, evt_ready,
    output evt_valid, evt_type, evt_code
  );
endinterface

// File: rtl/inf_key_ctrl.sv
// Key-event sequencer behind the NEC IR receiver.
// Turns decoded frames and repeat codes into PRESS / HOLD / RELEASE events.
// It detects a key release by repeat timeout and schedules auto-repeat HOLD events.
// Events are queued in a 4-entry {type,code} FIFO with a valid/ready handshake.
// Build option: define INF_KEY_HOLD_EN to generate HOLD events. When it is undefined,
// repeat codes only keep the key alive.
module inf_key_ctrl #(
  parameter logic [22:0] TIMEOUT_CYC = 23'd6_000_000,
  parameter logic [7:0]  HOLD_REP    = 8'd4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  inf_key_ctrl_if.slave bus,
  output logic          key_down,
  output logic          ovf
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_SWAP    = 2'd2
  } state_t;

  localparam logic [1:0]  EVT_PRESS   = 2'b01;
  localparam logic [1:0]  EVT_HOLD    = 2'b10;
  localparam logic [1:0]  EVT_RELEASE = 2'b11;
  localparam logic [22:0] TMO_LAST    = TIMEOUT_CYC - 23'd1;

`ifdef INF_KEY_HOLD_EN
  localparam bit HOLD_ENABLE = 1'b1;
`else
  localparam bit HOLD_ENABLE = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [22:0] tmo_q, tmo_d;
  logic [7:0]  rep_cnt_q, rep_cnt_d;
  logic [7:0]  cur_code_q, cur_code_d;
  logic [7:0]  lat_code_q, lat_code_d;
  logic        rep_en_q, rep_en_d;
  logic        key_down_q, key_down_d;
  logic [9:0]  mem_q [4];
  logic [9:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  logic        rep_pulse;
  logic [7:0]  rep_cnt_inc;
  logic        push;
  logic [9:0]  push_evt;
  logic        push_ok;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;

  assign rep_pulse   = bus.repeat_en & ~rep_en_q;
  assign rep_cnt_inc = (rep_cnt_q == 8'hFF) ? 8'hFF : rep_cnt_q + 8'd1;
  assign fifo_empty  = (count_q == 3'd0);
  assign fifo_full   = (count_q == 3'd4);
  assign pop         = ~fifo_empty & bus.evt_ready;
  assign push_ok     = push & (~fifo_full | pop);

  assign bus.evt_valid = ~fifo_empty;
  assign bus.evt_type  = fifo_empty ? 2'b00 : mem_q[rd_ptr_q][9:8];
  assign bus.evt_code  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
  assign key_down      = key_down_q;
  assign ovf           = ovf_q;

  // Key FSM: decide the next key state and which event, if any, to queue this cycle
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    rep_cnt_d  = rep_cnt_q;
    cur_code_d = cur_code_q;
    lat_code_d = lat_code_q;
    rep_en_d   = bus.repeat_en;
    push       = 1'b0;
    push_evt   = 10'd0;
    case (state_q)
      ST_IDLE: begin
        if (bus.frame_vld) begin
          push       = 1'b1;
          push_evt   = {EVT_PRESS, bus.cmd};
          cur_code_d = bus.cmd;
          rep_cnt_d  = 8'd0;
          tmo_d      = 23'd0;
          state_d    = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (bus.frame_vld) begin
          push       = 1'b1;
          push_evt   = {EVT_RELEASE, cur_code_q};
          lat_code_d = bus.cmd;
          state_d    = ST_SWAP;
        end else if (rep_pulse) begin
          tmo_d     = 23'd0;
          rep_cnt_d = rep_cnt_inc;
          if (HOLD_ENABLE && (rep_cnt_inc >= HOLD_REP)) begin
            push     = 1'b1;
            push_evt = {EVT_HOLD, cur_code_q};
          end
        end else if (tmo_q == TMO_LAST) begin
          push     = 1'b1;
          push_evt = {EVT_RELEASE, cur_code_q};
          tmo_d    = 23'd0;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 23'd1;
        end
      end
      ST_SWAP: begin
        push       = 1'b1;
        push_evt   = {EVT_PRESS, lat_code_q};
        cur_code_d = lat_code_q;
        rep_cnt_d  = 8'd0;
        tmo_d      = 23'd0;
        state_d    = ST_PRESSED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    key_down_d = (state_d != ST_IDLE);
  end

  // Event FIFO: a push into a full FIFO succeeds only when the head leaves the same cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_evt;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else if (push) begin
      ovf_d = 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State register; reset drops any held key silently and empties the FIFO
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      tmo_q      <= 23'd0;
      rep_cnt_q  <= 8'd0;
      cur_code_q <= 8'd0;
      lat_code_q <= 8'd0;
      rep_en_q   <= 1'b0;
      key_down_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      rep_cnt_q  <= rep_cnt_d;
      cur_code_q <= cur_code_d;
      lat_code_q <= lat_code_d;
      rep_en_q   <= rep_en_d;
      key_down_q <= key_down_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_inf_key_ctrl.sv
// Self-checking bench for inf_key_ctrl with a short timeout.
// A behavioural model of key/event behaviour is checked on every clock.
// Directed scenarios add literal expectations on top of the model.
// Honours INF_KEY_HOLD_EN the same way as the design.
module tb_inf_key_ctrl;

  localparam logic [22:0] T_CYC  = 23'd40;
  localparam logic [7:0]  HOLD_N = 8'd4;

`ifdef INF_KEY_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic sys_clk;
  logic sys_rst_n;
  logic key_down;
  logic ovf;

  inf_key_ctrl_if bus ();

  inf_key_ctrl #(
    .TIMEOUT_CYC (T_CYC),
    .HOLD_REP    (HOLD_N)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .key_down  (key_down),
    .ovf       (ovf)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Compare one observed value with its required value
  task automatic check_output(input string name, input int actual, input int expected);
    n_vectors++;
    if (actual != expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a held key, a pending key swap, a silence counter, and the event queue
  logic [9:0] exp_q[$];
  bit         m_held, m_swap, m_ovf, m_prev_rep;
  logic [7:0] m_code, m_swap_code;
  int         m_reps, m_silence;
  bit         s_rst, s_frame, s_rep, s_ready, have_evt, do_pop;
  logic [7:0] s_cmd;
  logic [9:0] new_evt;

  always begin : model_and_compare
    @(posedge sys_clk);
    s_rst   = sys_rst_n;
    s_frame = bus.frame_vld;
    s_cmd   = bus.cmd;
    s_rep   = bus.repeat_en;
    s_ready = bus.evt_ready;
    #1;
    if (!s_rst) begin
      exp_q.delete();
      m_held = 0; m_swap = 0; m_ovf = 0; m_prev_rep = 0;
      m_code = 8'h00; m_swap_code = 8'h00; m_reps = 0; m_silence = 0;
    end else begin
      do_pop   = (exp_q.size() != 0) && s_ready;
      have_evt = 0;
      new_evt  = 10'd0;
      if (m_swap) begin
        have_evt = 1; new_evt = {2'b01, m_swap_code};
        m_code = m_swap_code; m_reps = 0; m_silence = 0; m_swap = 0;
      end else if (!m_held) begin
        if (s_frame) begin
          have_evt = 1; new_evt = {2'b01, s_cmd};
          m_held = 1; m_code = s_cmd; m_reps = 0; m_silence = 0;
        end
      end else if (s_frame) begin
        have_evt = 1; new_evt = {2'b11, m_code};
        m_swap = 1; m_swap_code = s_cmd;
      end else if (s_rep && !m_prev_rep) begin
        m_silence = 0;
        if (m_reps < 255) m_reps++;
        if (HOLD_EN && m_reps >= int'(HOLD_N)) begin
          have_evt = 1; new_evt = {2'b10, m_code};
        end
      end else begin
        m_silence++;
        if (m_silence == int'(T_CYC)) begin
          have_evt = 1; new_evt = {2'b11, m_code};
          m_held = 0;
        end
      end
      m_prev_rep = s_rep;
      if (do_pop) void'(exp_q.pop_front());
      if (have_evt) begin
        if (exp_q.size() < 4) exp_q.push_back(new_evt);
        else m_ovf = 1;
      end
    end
    check_output("evt_valid", int'(bus.evt_valid), (exp_q.size() != 0) ? 1 : 0);
    check_output("evt_type", int'(bus.evt_type), (exp_q.size() != 0) ? int'(exp_q[0][9:8]) : 0);
    check_output("evt_code", int'(bus.evt_code), (exp_q.size() != 0) ? int'(exp_q[0][7:0]) : 0);
    check_output("key_down", int'(key_down), int'(m_held));
    check_output("ovf", int'(ovf), int'(m_ovf));
  end

  // Event tally of what the consumer sees while ready is held high
  bit tally_on = 0;
  int tally[4];
  int tally_bad_code;
  logic [7:0] tally_code;

  task automatic tally_clear(input logic [7:0] code);
    for (int i = 0; i < 4; i++) tally[i] = 0;
    tally_bad_code = 0;
    tally_code = code;
  endtask

  // Drive one cycle of inputs, then return at the following falling edge
  task automatic apply_stimulus(input bit f, input logic [7:0] c, input bit r, input bit rdy);
    bus.frame_vld = f;
    bus.cmd       = c;
    bus.repeat_en = r;
    bus.evt_ready = rdy;
    @(negedge sys_clk);
    if (tally_on && bus.evt_valid) begin
      tally[bus.evt_type]++;
      if (bus.evt_code != tally_code) tally_bad_code++;
    end
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 1'b0, rdy);
  endtask

  task automatic pulse_reset();
    sys_rst_n = 1'b0;
    idle_cycles(2, 1'b1);
    sys_rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int  rel_k;
  bit  found;
  int  mode;
  bit  r_rep;
  logic [9:0] drain_exp [4];

  initial begin : stimulus
    sys_rst_n     = 1'b0;
    bus.frame_vld = 1'b0;
    bus.cmd       = 8'h00;
    bus.repeat_en = 1'b0;
    bus.evt_ready = 1'b1;
    idle_cycles(2, 1'b1);
    check_output("reset_evt_valid", int'(bus.evt_valid), 0);
    check_output("reset_evt_type", int'(bus.evt_type), 0);
    check_output("reset_evt_code", int'(bus.evt_code), 0);
    check_output("reset_key_down", int'(key_down), 0);
    check_output("reset_ovf", int'(ovf), 0);
    sys_rst_n = 1'b1;
    idle_cycles(2, 1'b1);

    $display("[TB] scenario 1: single press with timeout release");
    apply_stimulus(1'b1, 8'h45, 1'b0, 1'b1);
    check_output("s1_press_valid", int'(bus.evt_valid), 1);
    check_output("s1_press_type", int'(bus.evt_type), 1);
    check_output("s1_press_code", int'(bus.evt_code), 8'h45);
    check_output("s1_key_down", int'(key_down), 1);
    found = 0;
    rel_k = -1;
    for (int k = 1; k <= 60 && !found; k++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
      if (bus.evt_valid && bus.evt_type == 2'b11) begin
        found = 1;
        rel_k = k;
      end
    end
    check_output("s1_release_seen", int'(found), 1);
    check_output("s1_release_delay", rel_k, 40);
    check_output("s1_release_code", int'(bus.evt_code), 8'h45);
    check_output("s1_key_up", int'(key_down), 0);
    idle_cycles(3, 1'b1);

    $display("[TB] scenario 2: press with six repeats");
    tally_clear(8'h16);
    tally_on = 1;
    apply_stimulus(1'b1, 8'h16, 1'b0, 1'b1);
    for (int rp = 0; rp < 6; rp++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);
      idle_cycles(8, 1'b1);
      check_output("s2_key_held", int'(key_down), 1);
    end
    idle_cycles(60, 1'b1);
    tally_on = 0;
    check_output("s2_press_count", tally[1], 1);
    check_output("s2_hold_count", tally[2], HOLD_EN ? 3 : 0);
    check_output("s2_release_count", tally[3], 1);
    check_output("s2_code_errors", tally_bad_code, 0);
    check_output("s2_key_up", int'(key_down), 0);

    $display("[TB] scenario 3: key swap");
    apply_stimulus(1'b1, 8'h0C, 1'b0, 1'b1);
    idle_cycles(3, 1'b1);
    apply_stimulus(1'b1, 8'h18, 1'b0, 1'b1);
    check_output("s3_release_type", int'(bus.evt_type), 3);
    check_output("s3_release_code", int'(bus.evt_code), 8'h0C);
    check_output("s3_key_down_a", int'(key_down), 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("s3_press_type", int'(bus.evt_type), 1);
    check_output("s3_press_code", int'(bus.evt_code), 8'h18);
    check_output("s3_key_down_b", int'(key_down), 1);
    idle_cycles(50, 1'b1);

    $display("[TB] scenario 4: overflow and drain");
    pulse_reset();
    apply_stimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("s4_no_ovf_yet", int'(ovf), 0);
    apply_stimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("s4_ovf", int'(ovf), 1);
    drain_exp[0] = {2'b01, 8'hA1};
    drain_exp[1] = {2'b11, 8'hA1};
    drain_exp[2] = {2'b01, 8'hB2};
    drain_exp[3] = {2'b11, 8'hB2};
    for (int i = 0; i < 4; i++) begin
      check_output("s4_drain_valid", int'(bus.evt_valid), 1);
      check_output("s4_drain_head", int'({bus.evt_type, bus.evt_code}), int'(drain_exp[i]));
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
    check_output("s4_empty", int'(bus.evt_valid), 0);
    check_output("s4_ovf_sticky", int'(ovf), 1);
    idle_cycles(50, 1'b1);

    $display("[TB] scenario 5: orphan repeats and reset while pressed");
    pulse_reset();
    tally_clear(8'h00);
    tally_on = 1;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);
      idle_cycles(3, 1'b1);
    end
    tally_on = 0;
    check_output("s5_orphan_events", tally[1] + tally[2] + tally[3], 0);
    check_output("s5_orphan_key_down", int'(key_down), 0);
    apply_stimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h6B, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("s5_queued_valid", int'(bus.evt_valid), 1);
    check_output("s5_pressed", int'(key_down), 1);
    sys_rst_n = 1'b0;
    #1;
    check_output("s5_rst_evt_valid", int'(bus.evt_valid), 0);
    check_output("s5_rst_evt_type", int'(bus.evt_type), 0);
    check_output("s5_rst_key_down", int'(key_down), 0);
    check_output("s5_rst_ovf", int'(ovf), 0);
    idle_cycles(2, 1'b1);
    sys_rst_n = 1'b1;
    tally_clear(8'h00);
    tally_on = 1;
    idle_cycles(60, 1'b1);
    tally_on = 0;
    check_output("s5_no_release_after_reset", tally[1] + tally[2] + tally[3], 0);

    $display("[TB] randomized phase");
    mode  = 0;
    r_rep = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) pulse_reset();
      if (c % 250 == 0) mode = $urandom_range(0, 2);
      if (mode != 0 && $urandom_range(0, 5) == 0) r_rep = ~r_rep;
      if (mode == 0) r_rep = 1'b0;
      apply_stimulus(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                     8'($urandom_range(0, 255)),
                     r_rep,
                     (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 8));
    end
    idle_cycles(60, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
